// File: rtl/adder_share_arbiter.sv
// Round-robin arbiter sharing one external combinational adder among NUM_REQ requesters.
// Define ADD_SHARE_SAT_EN to saturate rsp_sum to all ones when the adder carries out.
module adder_share_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned ADD_BIT = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*ADD_BIT-1:0] req_a,
  input  logic [NUM_REQ*ADD_BIT-1:0] req_b,
  output logic [NUM_REQ-1:0]         rsp_valid,
  input  logic [NUM_REQ-1:0]         rsp_ready,
  output logic [ADD_BIT-1:0]         rsp_sum,
  output logic                       rsp_carry,
  output logic [ADD_BIT-1:0]         add_a,
  output logic [ADD_BIT-1:0]         add_b,
  input  logic [ADD_BIT-1:0]         add_sum,
  input  logic                       add_carry,
  output logic                       busy
);

  localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_EXEC, S_RESP} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     ptr_q, ptr_d;
  logic [PTR_W-1:0]     gnt_q, gnt_d;
  logic [ADD_BIT-1:0]   add_a_q, add_a_d;
  logic [ADD_BIT-1:0]   add_b_q, add_b_d;
  logic [ADD_BIT-1:0]   sum_q, sum_d;
  logic                 carry_q, carry_d;
  logic [NUM_REQ-1:0]   rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;

  logic [ADD_BIT-1:0]   a_lane [NUM_REQ];
  logic [ADD_BIT-1:0]   b_lane [NUM_REQ];
  logic                 found;
  logic [PTR_W-1:0]     winner;
  logic [NUM_REQ-1:0]   grant;
  int unsigned          idx;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    assign a_lane[i] = req_a[i*ADD_BIT +: ADD_BIT];
    assign b_lane[i] = req_b[i*ADD_BIT +: ADD_BIT];
  end

  // Round-robin search starting just above the last winner.
  always_comb begin
    found  = 1'b0;
    winner = ptr_q;
    idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(ptr_q) + k) % NUM_REQ;
      if (!found && req_valid[PTR_W'(idx)]) begin
        found  = 1'b1;
        winner = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_d       = gnt_q;
    add_a_d     = add_a_q;
    add_b_d     = add_b_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    busy_d      = busy_q;
    grant       = '0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant   = NUM_REQ'(1) << winner;
          add_a_d = a_lane[winner];
          add_b_d = b_lane[winner];
          gnt_d   = winner;
          ptr_d   = winner;
          busy_d  = 1'b1;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        add_a_d     = '0;
        add_b_d     = '0;
        carry_d     = add_carry;
`ifdef ADD_SHARE_SAT_EN
        sum_d       = add_carry ? '1 : add_sum;
`else
        sum_d       = add_sum;
`endif
        rsp_valid_d = NUM_REQ'(1) << gnt_q;
        state_d     = S_RESP;
      end
      S_RESP: begin
        if (rsp_ready[gnt_q]) begin
          rsp_valid_d = '0;
          busy_d      = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      ptr_q       <= PTR_W'(NUM_REQ - 1);
      gnt_q       <= '0;
      add_a_q     <= '0;
      add_b_q     <= '0;
      sum_q       <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_q       <= gnt_d;
      add_a_q     <= add_a_d;
      add_b_q     <= add_b_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // The grant is combinational so a requester sees acceptance in its request cycle.
  assign req_ready = reset ? '0 : grant;
  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = sum_q;
  assign rsp_carry = carry_q;
  assign add_a     = add_a_q;
  assign add_b     = add_b_q;
  assign busy      = busy_q;

endmodule
